// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_ctrl_if
// Description : Host-side bundle for the 7-segment scan sequencer. The host
//               drives the value to show, the decimal-point mask, the load
//               strobe and the blanking enable; the sequencer reports
//               whether an update is still pending and acknowledges each one.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_ctrl_if;
  logic [15:0] dat;       // value to display, dat[3:0] is the rightmost digit
  logic [3:0]  dp_mask;   // bit k lights the decimal point of digit k
  logic        load;      // one-cycle strobe capturing dat/dp_mask
  logic        blank_lz;  // leading-zero blanking enable, used live
  logic        busy;      // a pending value is waiting for a frame boundary
  logic        upd_ack;   // one-cycle pulse after pending became active

  // Host side: produces the value, observes the buffer status
  modport master (
    output dat,
    output dp_mask,
    output load,
    output blank_lz,
    input  busy,
    input  upd_ack
  );

  // Sequencer side
  modport slave (
    input  dat,
    input  dp_mask,
    input  load,
    input  blank_lz,
    output busy,
    output upd_ack
  );
endinterface
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_ctrl
// Description : Scan sequencer for a 4-digit common-anode 7-segment display.
//               Divides the system clock into scan slots, walks the four
//               digits, decodes hex nibbles with per-digit decimal points and
//               optional leading-zero blanking, and double-buffers the shown
//               value so that updates only land on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000  // clocks per scan slot, >= 2
) (
  input  logic                   clk,
  input  logic                   rst,
  disp_scan_ctrl_if.slave        host,
  output logic                   ce1ms,
  output logic                   frame_end,
  output logic [3:0]             AN,
  output logic [7:0]             SEG
);

  // Prescaler sizing: enough bits to hold CLK_DIV-1
  localparam int unsigned        PRESC_W    = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  // The display stays dark until the first scan strobe after reset, so that
  // the very first lit slot is a full-length digit-0 slot.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [1:0]          idx_q, idx_d;

  logic [15:0]         act_dat_q, act_dat_d;
  logic [3:0]          act_dp_q, act_dp_d;
  logic [15:0]         pend_dat_q, pend_dat_d;
  logic [3:0]          pend_dp_q, pend_dp_d;
  logic                busy_q, busy_d;
  logic                upd_ack_q, upd_ack_d;

  logic [3:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic                presc_last;
  logic [3:0]          cur_nib;
  logic [3:0]          lz_zero;    // bit k: nibbles k..3 of active are all zero
  logic                cur_blank;

  // Hex nibble to active-low segments a..g (bit 0 = a)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot prescaler: 0..CLK_DIV-1, strobe on the last count
  always_comb begin
    presc_last = (presc_q == PRESC_LAST);
    presc_d    = presc_last ? '0 : presc_q + PRESC_ONE;
  end

  assign ce1ms     = presc_last;
  assign frame_end = ce1ms & (idx_q == 2'd3);

  // Run/idle sequencing and digit index advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        // First strobe only starts the scan; digit 0 is shown first
        if (ce1ms) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ce1ms) idx_d = idx_q + 2'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending/active double buffer with frame-boundary commit
  always_comb begin
    act_dat_d  = act_dat_q;
    act_dp_d   = act_dp_q;
    pend_dat_d = pend_dat_q;
    pend_dp_d  = pend_dp_q;
    busy_d     = busy_q;
    upd_ack_d  = 1'b0;

    // Later loads simply overwrite the pending copy
    if (host.load) begin
      pend_dat_d = host.dat;
      pend_dp_d  = host.dp_mask;
    end

    if (frame_end && host.load) begin
      // Load lands exactly on the boundary: commit the fresh value directly
      act_dat_d = host.dat;
      act_dp_d  = host.dp_mask;
      busy_d    = 1'b0;
      upd_ack_d = 1'b1;
    end else if (frame_end && busy_q) begin
      act_dat_d = pend_dat_q;
      act_dp_d  = pend_dp_q;
      busy_d    = 1'b0;
      upd_ack_d = 1'b1;
    end else if (host.load) begin
      busy_d = 1'b1;
    end
  end

  assign host.busy    = busy_q;
  assign host.upd_ack = upd_ack_q;

  // Leading-zero detection over the active value, from the top digit down
  always_comb begin
    lz_zero[3] = (act_dat_q[15:12] == 4'h0);
    lz_zero[2] = lz_zero[3] & (act_dat_q[11:8] == 4'h0);
    lz_zero[1] = lz_zero[2] & (act_dat_q[7:4] == 4'h0);
    lz_zero[0] = 1'b0;  // the rightmost digit always shows
    cur_nib    = act_dat_q[{idx_q, 2'b00} +: 4];
    cur_blank  = host.blank_lz & lz_zero[idx_q];
  end

  // Next anode/cathode pattern for the current digit
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (state_q == ST_RUN) begin
      an_d       = ~(4'b0001 << idx_q);
      seg_d[7]   = ~act_dp_q[idx_q];
      seg_d[6:0] = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      idx_q      <= 2'd0;
      act_dat_q  <= 16'h0000;
      act_dp_q   <= 4'h0;
      pend_dat_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      busy_q     <= 1'b0;
      upd_ack_q  <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      act_dat_q  <= act_dat_d;
      act_dp_q   <= act_dp_d;
      pend_dat_q <= pend_dat_d;
      pend_dp_q  <= pend_dp_d;
      busy_q     <= busy_d;
      upd_ack_q  <= upd_ack_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan_ctrl
// Description : Self-checking bench for disp_scan_ctrl with CLK_DIV = 4.
//               Directed scenarios plus a randomized run against a timing
//               model derived from the elapsed clock count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 4 * CLK_DIV;

  localparam logic [6:0] HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce1ms;
  logic       frame_end;
  logic [3:0] AN;
  logic [7:0] SEG;

  int tests_run    = 0;
  int tests_failed = 0;

  disp_scan_ctrl_if host_if();

  disp_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_if),
    .ce1ms     (ce1ms),
    .frame_end (frame_end),
    .AN        (AN),
    .SEG       (SEG)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // n = rising edges seen since reset was released.
  function automatic bit exp_ce(int n);
    return (n % CLK_DIV) == (CLK_DIV - 1);
  endfunction

  function automatic bit exp_run(int n);
    return (n / CLK_DIV) >= 1;
  endfunction

  function automatic int exp_idx(int n);
    int s;
    s = n / CLK_DIV;
    return (s == 0) ? 0 : ((s - 1) % 4);
  endfunction

  function automatic bit exp_fe(int n);
    return exp_ce(n) && exp_run(n) && (exp_idx(n) == 3);
  endfunction

  function automatic logic [7:0] exp_seg(logic [15:0] d, logic [3:0] dp, int k, bit blz);
    logic [15:0] upper;
    logic [6:0]  s;
    upper = d >> (4 * k);
    s = (blz && k != 0 && upper == 16'h0000) ? 7'h7F : HEX_LUT[upper[3:0]];
    return {~dp[k], s};
  endfunction

  int          m_n        = 0;
  logic [15:0] m_act_dat  = '0;
  logic [15:0] m_pend_dat = '0;
  logic [3:0]  m_act_dp   = '0;
  logic [3:0]  m_pend_dp  = '0;
  bit          m_busy     = 1'b0;
  bit          m_ack      = 1'b0;
  logic [3:0]  m_an       = 4'hF;
  logic [7:0]  m_seg      = 8'hFF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0; m_act_dat <= '0; m_pend_dat <= '0; m_act_dp <= '0; m_pend_dp <= '0;
      m_busy <= 1'b0; m_ack <= 1'b0; m_an <= 4'hF; m_seg <= 8'hFF;
    end else begin
      m_an  <= exp_run(m_n) ? ~(4'b0001 << exp_idx(m_n)) : 4'hF;
      m_seg <= exp_run(m_n) ? exp_seg(m_act_dat, m_act_dp, exp_idx(m_n), host_if.blank_lz) : 8'hFF;
      m_ack <= exp_fe(m_n) && (host_if.load || m_busy);
      if (exp_fe(m_n) && host_if.load) begin
        m_act_dat <= host_if.dat; m_act_dp <= host_if.dp_mask;
      end else if (exp_fe(m_n) && m_busy) begin
        m_act_dat <= m_pend_dat; m_act_dp <= m_pend_dp;
      end
      if (host_if.load) begin
        m_pend_dat <= host_if.dat; m_pend_dp <= host_if.dp_mask;
      end
      m_busy <= exp_fe(m_n) ? 1'b0 : (host_if.load ? 1'b1 : m_busy);
      m_n    <= m_n + 1;
    end
  end

  // ---------------- utilities (timing only) ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (host_if.upd_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic collect_frame(output logic [3:0][7:0] segs);
    segs = '1;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      case (AN)
        4'b1110: segs[0] = SEG;
        4'b1101: segs[1] = SEG;
        4'b1011: segs[2] = SEG;
        4'b0111: segs[3] = SEG;
        default: ;
      endcase
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    host_if.dat = d; host_if.dp_mask = dp; host_if.load = 1'b1;
    tick();
    host_if.load = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [17:0] rv;
    int first_ce;
    rv = {AN, SEG, host_if.busy, host_if.upd_ack, ce1ms, frame_end};
    tests_run++;
    if (rv !== {4'hF, 8'hFF, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", rv, {4'hF, 8'hFF, 4'b0000});
    end
    rst = 1'b0;
    repeat (FRAME + 1) tick();
    do_load(16'hFFFF, 4'hF);
    tests_run++;
    if (host_if.busy !== 1'b1 || AN === 4'hF) begin
      tests_failed++;
      $display("FAIL pre_reset_state: busy=%b AN=%b expected busy=1 and a lit digit", host_if.busy, AN);
    end
    // asynchronous reset mid-cycle, mid-scan
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    rv = {AN, SEG, host_if.busy, host_if.upd_ack, ce1ms, frame_end};
    tests_run++;
    if (rv !== {4'hF, 8'hFF, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", rv, {4'hF, 8'hFF, 4'b0000});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rv = {AN, SEG, host_if.busy, host_if.upd_ack, ce1ms, frame_end};
      tests_run++;
      if (rv !== {4'hF, 8'hFF, 4'b0000}) begin
        tests_failed++;
        $display("FAIL reset_cycle%0d: got %h expected %h", c, rv, {4'hF, 8'hFF, 4'b0000});
      end
    end
    rst = 1'b0;
    first_ce = -1;
    for (int k = 0; k <= CLK_DIV + 1; k++) begin
      if (k > 0) tick();
      if (ce1ms === 1'b1 && first_ce < 0) first_ce = k;
      if (k == CLK_DIV + 1) begin
        tests_run++;
        if (AN !== 4'b1110) begin
          tests_failed++;
          $display("FAIL reset_first_an: got %b expected 1110", AN);
        end
      end
    end
    tests_run++;
    if (first_ce != CLK_DIV - 1) begin
      tests_failed++;
      $display("FAIL reset_first_ce: got cycle %0d expected %0d", first_ce, CLK_DIV - 1);
    end
  endtask

  task automatic test_scan_zero();
    logic [3:0] an_seq[$];
    logic [3:0] an_exp [5];
    int last_ce;
    an_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    an_seq.push_back(AN);
    last_ce = -1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      tests_run++;
      if (ce1ms !== exp_ce(m_n) || frame_end !== exp_fe(m_n)) begin
        tests_failed++;
        $display("FAIL scan_strobes c%0d: got ce=%b fe=%b expected ce=%b fe=%b",
                 c, ce1ms, frame_end, exp_ce(m_n), exp_fe(m_n));
      end
      tests_run++;
      if (AN !== m_an || SEG !== m_seg) begin
        tests_failed++;
        $display("FAIL scan_display c%0d: got AN=%b SEG=%h expected AN=%b SEG=%h", c, AN, SEG, m_an, m_seg);
      end
      tests_run++;
      if (SEG[6:0] !== 7'h40) begin
        tests_failed++;
        $display("FAIL scan_zero_seg c%0d: got %h expected 40", c, SEG[6:0]);
      end
      if (frame_end === 1'b1) begin
        tests_run++;
        if (AN !== 4'b0111 || ce1ms !== 1'b1) begin
          tests_failed++;
          $display("FAIL scan_fe_slot c%0d: got AN=%b ce=%b expected AN=0111 ce=1", c, AN, ce1ms);
        end
      end
      if (ce1ms === 1'b1) begin
        if (last_ce >= 0) begin
          tests_run++;
          if (c - last_ce != CLK_DIV) begin
            tests_failed++;
            $display("FAIL scan_ce_period: got %0d expected %0d", c - last_ce, CLK_DIV);
          end
        end
        last_ce = c;
      end
      if (AN !== an_seq[$]) an_seq.push_back(AN);
    end
    tests_run++;
    if (an_seq.size() < 5) begin
      tests_failed++;
      $display("FAIL scan_an_count: got %0d slots expected at least 5", an_seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (an_seq[i] !== an_exp[i]) begin
          tests_failed++;
          $display("FAIL scan_an_seq%0d: got %b expected %b", i, an_seq[i], an_exp[i]);
        end
      end
    end
  endtask

  task automatic test_load_midframe();
    bit ok;
    logic [3:0][7:0] segs;
    host_if.blank_lz = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (exp_run(m_n) && exp_idx(m_n) == 1 && (m_n % CLK_DIV) == 1) break;
      tick();
    end
    do_load(16'h3333, 4'h0);   // overwritten by the next load
    do_load(16'h12AF, 4'h0);
    tests_run++;
    if (host_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_busy: got %b expected 1", host_if.busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (host_if.upd_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tests_run++;
      if (host_if.busy !== 1'b1 || SEG[6:0] !== 7'h40) begin
        tests_failed++;
        $display("FAIL load_hold: got busy=%b SEG=%h expected busy=1 SEG=40", host_if.busy, SEG[6:0]);
      end
      tick();
    end
    tests_run++;
    if (!ok || host_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_ack: got ack_seen=%b busy=%b expected 1 and 0", ok, host_if.busy);
    end
    tick();
    tests_run++;
    if (host_if.upd_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_ack_width: got %b expected 0", host_if.upd_ack);
    end
    collect_frame(segs);
    tests_run++;
    if (segs[0][6:0] !== 7'h0E || segs[1][6:0] !== 7'h08 ||
        segs[2][6:0] !== 7'h24 || segs[3][6:0] !== 7'h79) begin
      tests_failed++;
      $display("FAIL load_frame: got d0..d3=%h %h %h %h expected 0E 08 24 79",
               segs[0][6:0], segs[1][6:0], segs[2][6:0], segs[3][6:0]);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [3:0][7:0] segs;
    host_if.blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    wait_ack(2 * FRAME, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL blank_ack: got timeout expected upd_ack");
    end
    collect_frame(segs);
    tests_run++;
    if (segs[3][6:0] !== 7'h7F || segs[2][6:0] !== 7'h7F ||
        segs[1][6:0] !== 7'h12 || segs[0][6:0] !== 7'h40) begin
      tests_failed++;
      $display("FAIL blank_on: got d3..d0=%h %h %h %h expected 7F 7F 12 40",
               segs[3][6:0], segs[2][6:0], segs[1][6:0], segs[0][6:0]);
    end
    host_if.blank_lz = 1'b0;
    collect_frame(segs);
    tests_run++;
    if (segs[3][6:0] !== 7'h40 || segs[2][6:0] !== 7'h40 ||
        segs[1][6:0] !== 7'h12 || segs[0][6:0] !== 7'h40) begin
      tests_failed++;
      $display("FAIL blank_off: got d3..d0=%h %h %h %h expected 40 40 12 40",
               segs[3][6:0], segs[2][6:0], segs[1][6:0], segs[0][6:0]);
    end
  endtask

  task automatic test_dp();
    bit ok;
    logic [3:0][7:0] segs;
    do_load(16'h8888, 4'b0100);
    wait_ack(2 * FRAME, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL dp_ack: got timeout expected upd_ack");
    end
    collect_frame(segs);
    tests_run++;
    if (segs[2] !== 8'h00 || segs[0] !== 8'h80 || segs[1] !== 8'h80 || segs[3] !== 8'h80) begin
      tests_failed++;
      $display("FAIL dp_frame: got d3..d0=%h %h %h %h expected 80 00 80 80",
               segs[3], segs[2], segs[1], segs[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [3:0][7:0] segs;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (frame_end === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!found || !exp_fe(m_n)) begin
      tests_failed++;
      $display("FAIL b2b_find_fe: got found=%b expected 1 at model boundary=%b", found, exp_fe(m_n));
    end
    do_load(16'hBEEF, 4'h0);
    tests_run++;
    if (host_if.busy !== 1'b0 || host_if.upd_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_bypass: got busy=%b ack=%b expected busy=0 ack=1", host_if.busy, host_if.upd_ack);
    end
    tick();
    tests_run++;
    if (host_if.busy !== 1'b0 || host_if.upd_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_after: got busy=%b ack=%b expected 0 0", host_if.busy, host_if.upd_ack);
    end
    collect_frame(segs);
    tests_run++;
    if (segs[0][6:0] !== 7'h0E || segs[1][6:0] !== 7'h06 ||
        segs[2][6:0] !== 7'h06 || segs[3][6:0] !== 7'h03) begin
      tests_failed++;
      $display("FAIL b2b_frame: got d0..d3=%h %h %h %h expected 0E 06 06 03",
               segs[0][6:0], segs[1][6:0], segs[2][6:0], segs[3][6:0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    for (int c = 0; c < 40 * FRAME; c++) begin
      tests_run++;
      if (ce1ms !== exp_ce(m_n) || frame_end !== exp_fe(m_n)) begin
        tests_failed++;
        $display("FAIL rand_strobes c%0d: got ce=%b fe=%b expected ce=%b fe=%b",
                 c, ce1ms, frame_end, exp_ce(m_n), exp_fe(m_n));
      end
      tests_run++;
      if (AN !== m_an || SEG !== m_seg) begin
        tests_failed++;
        $display("FAIL rand_display c%0d: got AN=%b SEG=%h expected AN=%b SEG=%h", c, AN, SEG, m_an, m_seg);
      end
      tests_run++;
      if (host_if.busy !== m_busy || host_if.upd_ack !== m_ack) begin
        tests_failed++;
        $display("FAIL rand_status c%0d: got busy=%b ack=%b expected busy=%b ack=%b",
                 c, host_if.busy, host_if.upd_ack, m_busy, m_ack);
      end
      host_if.load = ($urandom_range(0, 9) == 0);
      if (host_if.load) begin
        for (int j = 0; j < 4; j++)
          d[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        host_if.dat     = d;
        host_if.dp_mask = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 24) == 0) host_if.blank_lz = ~host_if.blank_lz;
      tick();
    end
    host_if.load = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    host_if.dat      = 16'h0000;
    host_if.dp_mask  = 4'h0;
    host_if.load     = 1'b0;
    host_if.blank_lz = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_scan_zero();
    test_load_midframe();
    test_blanking();
    test_dp();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a scenario stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
